pingpong_buf_64bit: RTL and testbench
=====================================

# pingpong_buf_64bit

Two-bank ping-pong buffer that sits directly upstream of `mux2_64bit`. It accepts 64-bit words from a valid/ready producer and stores them alternately in bank 0 and bank 1. It presents both banks side by side on the 128-bit `w` bus, with the read pointer on `s`, so the downstream 2:1 mux always drives the oldest unconsumed word on `f`. Consumption by the downstream side uses a valid/ready handshake.

## Interface
- `DATA_W`, 64, bank width; `w` width is 2*`DATA_W`; 64 is the only verified value.

Ports:
- `clk`  in  1  rising-edge clock; sole clock domain
- `reset`  in  1  synchronous, active-high reset
- `in_data`  in  DATA_W  word to store
- `in_valid`  in  1  producer has a word on `in_data`
- `in_ready`  out  1  target bank is empty; a word is accepted on `in_valid && in_ready`
- `w`  out  2*DATA_W  bank 1 in `w[127:64]`, bank 0 in `w[63:0]`; feeds the mux `w` input directly
- `s`  out  1  read pointer; feeds the mux `s` input (0 selects bank 0, 1 selects bank 1)
- `out_valid`  out  1  bank selected by `s` holds an unconsumed word
- `out_ready`  in  1  consumer takes the word; pop on `out_valid && out_ready`
- `count`  out  2  occupied banks, 0..2
- `flush`  in  1  present only with `PP_FLUSH_EN`

## Operation
- State registers:
  - `bank0`, `bank1` (DATA_W each)
  - `v0`, `v1` (per-bank occupied flags)
  - `wr_ptr`, `rd_ptr` (1 bit each)
- Combinational outputs:
  - `in_ready = ~v[wr_ptr]`
  - `out_valid = v[rd_ptr]`
  - `s = rd_ptr`
  - `count = v0 + v1`
- All combinational outputs derive from registers only. There is no combinational path from `in_valid` or `out_ready` to any output.
- Push (`in_valid && in_ready`):
  - `bank[wr_ptr] <= in_data`
  - `v[wr_ptr] <= 1`
  - `wr_ptr` toggles
- Pop (`out_valid && out_ready`):
  - `v[rd_ptr] <= 0`
  - `rd_ptr` toggles
  - Bank contents are not cleared; `w` keeps the stale data.
- Occupancy states:
  - EMPTY (count 0, `wr_ptr == rd_ptr`): push allowed, pop not.
  - ONE (count 1, pointers differ): push and pop both allowed; a simultaneous push and pop keeps count at 1 and touches different banks.
  - FULL (count 2, pointers equal): pop allowed, push not.
- Push and pop can never target the same bank in the same cycle.
- `in_valid` while `in_ready` = 0 is ignored, with no state change. The producer must hold the word.
- `out_ready` while `out_valid` = 0 is ignored.
- Pointer arithmetic is 1-bit wrap: bank 1 is followed by bank 0.
- Bit order: `f[0]` of the downstream mux is the MSB of the selected bank. The word read on `f[0:63]` therefore equals `in_data[63:0]` numerically.

## Timing
- Reset (synchronous, at `clk` edge with `reset` = 1):
  - `bank0` = `bank1` = 0, so `w` = 0
  - `v0` = `v1` = 0
  - `wr_ptr` = `rd_ptr` = 0, so `s` = 0
  - `out_valid` = 0, `in_ready` = 1, `count` = 0
- `reset` has priority over push, pop and flush in the same cycle.
- Reset mid-operation discards all stored words.
- Latency: a word pushed at edge k appears on `w` with `out_valid` = 1 and a matching `s` in the cycle after edge k. The mux `f` output is valid in that same cycle (the mux is combinational).
- Throughput: one word per cycle sustained in the ONE state with `in_valid` = `out_ready` = 1.
- From EMPTY, the first push costs one bubble.
- `in_ready` deasserts the cycle after the second push without a pop (FULL).
- `in_ready` reasserts the cycle after a pop from FULL.

## Configuration
- `PP_FLUSH_EN` defined:
  - Adds the `flush` input.
  - `flush` = 1 at an edge clears `v0`, `v1`, `wr_ptr` and `rd_ptr` to 0 and leaves bank data intact.
  - Flush overrides a push or pop in the same cycle; the pushed word is dropped.
- `PP_FLUSH_EN` undefined:
  - No `flush` port.
  - Only `reset` clears occupancy.

## Test plan
- Reset, then push `in_data` = 64'hDEAD_BEEF_0000_0001 with `out_ready` = 0 -> next cycle: `w[63:0]` = that value, `s` = 0, `out_valid` = 1, `count` = 1, `in_ready` = 1.
- Push A = 64'h1, then B = 64'h2 with `out_ready` = 0 -> `count` = 2, `in_ready` = 0, `w` = {64'h2, 64'h1}. A third word C held on `in_valid` is not accepted and `w` is unchanged.
- From FULL, `out_ready` = 1 for two cycles -> the mux `f` shows 64'h1 with `s` = 0, then 64'h2 with `s` = 1. Finally `count` = 0, `out_valid` = 0, `s` = 0.
- Streaming 100 incrementing words with `in_valid` = `out_ready` = 1 -> received in order with no loss or duplication. After the first word, one word is delivered per cycle, and `s` alternates 0,1,0,1.
- Assert `reset` in FULL while `in_valid` = `out_ready` = 1 -> next cycle: `w` = 0, `count` = 0, `s` = 0, `out_valid` = 0, `in_ready` = 1.
- With `PP_FLUSH_EN`: from count 1, assert `flush` together with a push of 64'h5 -> next cycle `count` = 0 and `out_valid` = 0. The bank contents keep their prior values.

Source files
------------

// File: rtl/pingpong_buf_64bit.sv
// Two-bank ping-pong buffer feeding mux2_64bit: banks side by side on w, read pointer on s.
// Optional synchronous occupancy flush input is enabled by defining PP_FLUSH_EN.
module pingpong_buf_64bit #(
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [2*DATA_W-1:0] w,
    output logic                s,
    output logic                out_valid,
    input  logic                out_ready,
`ifdef PP_FLUSH_EN
    input  logic                flush,
`endif
    output logic [1:0]          count
);

    logic [DATA_W-1:0] bank0_r, bank1_r;
    logic              v0_r, v1_r;
    logic              wr_ptr_r, rd_ptr_r;

    logic [DATA_W-1:0] bank0_n_s, bank1_n_s;
    logic              v0_n_s, v1_n_s;
    logic              wr_ptr_n_s, rd_ptr_n_s;
    logic              push_s, pop_s, flush_s;

`ifdef PP_FLUSH_EN
    assign flush_s = flush;
`else
    assign flush_s = 1'b0;
`endif

    // Every output is a pure function of registered state.
    assign in_ready  = wr_ptr_r ? ~v1_r : ~v0_r;
    assign out_valid = rd_ptr_r ? v1_r : v0_r;
    assign s         = rd_ptr_r;
    assign count     = {1'b0, v0_r} + {1'b0, v1_r};
    assign w         = {bank1_r, bank0_r};

    assign push_s = in_valid && in_ready;
    assign pop_s  = out_valid && out_ready;

    // Next-state: push and pop always address different banks, so both may apply at once.
    always_comb begin
        bank0_n_s  = bank0_r;
        bank1_n_s  = bank1_r;
        v0_n_s     = v0_r;
        v1_n_s     = v1_r;
        wr_ptr_n_s = wr_ptr_r;
        rd_ptr_n_s = rd_ptr_r;
        if (flush_s) begin
            // Occupancy is cleared but bank data stays visible on w.
            v0_n_s     = 1'b0;
            v1_n_s     = 1'b0;
            wr_ptr_n_s = 1'b0;
            rd_ptr_n_s = 1'b0;
        end else begin
            if (push_s) begin
                if (wr_ptr_r) begin
                    bank1_n_s = in_data;
                    v1_n_s    = 1'b1;
                end else begin
                    bank0_n_s = in_data;
                    v0_n_s    = 1'b1;
                end
                wr_ptr_n_s = ~wr_ptr_r;
            end else begin
                wr_ptr_n_s = wr_ptr_r;
            end
            if (pop_s) begin
                if (rd_ptr_r) begin
                    v1_n_s = 1'b0;
                end else begin
                    v0_n_s = 1'b0;
                end
                rd_ptr_n_s = ~rd_ptr_r;
            end else begin
                rd_ptr_n_s = rd_ptr_r;
            end
        end
    end

    // State registers with synchronous reset taking priority over everything else.
    always_ff @(posedge clk) begin
        if (reset) begin
            bank0_r  <= '0;
            bank1_r  <= '0;
            v0_r     <= 1'b0;
            v1_r     <= 1'b0;
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
        end else begin
            bank0_r  <= bank0_n_s;
            bank1_r  <= bank1_n_s;
            v0_r     <= v0_n_s;
            v1_r     <= v1_n_s;
            wr_ptr_r <= wr_ptr_n_s;
            rd_ptr_r <= rd_ptr_n_s;
        end
    end

endmodule

// File: tb/tb_pingpong_buf_64bit.sv
// Self-checking bench for pingpong_buf_64bit: directed scenarios plus an ordering scoreboard.
module tb_pingpong_buf_64bit;

    logic         clk = 1'b0;
    logic         reset;
    logic [63:0]  in_data;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] w;
    logic         s;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   count;
`ifdef PP_FLUSH_EN
    logic         flush;
`endif

    int tests  = 0;
    int failed = 0;
    int pop_cnt = 0;
    logic [63:0] sb[$];

    pingpong_buf_64bit #(.DATA_W(64)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .w(w), .s(s), .out_valid(out_valid),
        .out_ready(out_ready),
`ifdef PP_FLUSH_EN
        .flush(flush),
`endif
        .count(count)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Word currently driven on the downstream mux output f.
    function automatic logic [63:0] mux_f(input logic [127:0] wv, input logic sv);
        return sv ? wv[127:64] : wv[63:0];
    endfunction

    // One clock: record accepted words, check popped words against the scoreboard.
    task automatic tick();
        logic [63:0] exp_v;
        if (in_valid && in_ready) sb.push_back(in_data);
        if (out_valid && out_ready) begin
            pop_cnt++;
            tests++;
            if (sb.size() == 0) begin
                failed++;
                $display("FAIL sb_pop: got %h but no word expected", mux_f(w, s));
            end else begin
                exp_v = sb.pop_front();
                if (mux_f(w, s) !== exp_v) begin
                    failed++;
                    $display("FAIL sb_data: got %h expected %h", mux_f(w, s), exp_v);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = 64'h0;
        @(posedge clk); #1;
        reset = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        in_data = 64'hFFFF_0000_FFFF_0000; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        do_reset();
        tests++; if (w !== 128'h0) begin failed++; $display("FAIL rst_w: got %h expected 0", w); end
        tests++; if (s !== 1'b0) begin failed++; $display("FAIL rst_s: got %b expected 0", s); end
        tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        tests++; if (in_ready !== 1'b1) begin failed++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
        tests++; if (count !== 2'd0) begin failed++; $display("FAIL rst_count: got %0d expected 0", count); end
    endtask

    task automatic test_single_push();
        do_reset();
        in_data = 64'hDEAD_BEEF_0000_0001; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        tests++; if (w[63:0] !== 64'hDEAD_BEEF_0000_0001) begin failed++; $display("FAIL single_w0: got %h expected deadbeef00000001", w[63:0]); end
        tests++; if (s !== 1'b0) begin failed++; $display("FAIL single_s: got %b expected 0", s); end
        tests++; if (out_valid !== 1'b1) begin failed++; $display("FAIL single_out_valid: got %b expected 1", out_valid); end
        tests++; if (count !== 2'd1) begin failed++; $display("FAIL single_count: got %0d expected 1", count); end
        tests++; if (in_ready !== 1'b1) begin failed++; $display("FAIL single_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_full_backpressure();
        do_reset();
        in_valid = 1'b1; out_ready = 1'b0;
        in_data = 64'h1; tick();
        in_data = 64'h2; tick();
        tests++; if (count !== 2'd2) begin failed++; $display("FAIL full_count: got %0d expected 2", count); end
        tests++; if (in_ready !== 1'b0) begin failed++; $display("FAIL full_in_ready: got %b expected 0", in_ready); end
        tests++; if (w !== {64'h2, 64'h1}) begin failed++; $display("FAIL full_w: got %h expected {2,1}", w); end
        in_data = 64'h3; tick(); tick();
        in_valid = 1'b0;
        tests++; if (w !== {64'h2, 64'h1}) begin failed++; $display("FAIL full_hold_w: got %h expected {2,1}", w); end
        tests++; if (count !== 2'd2) begin failed++; $display("FAIL full_hold_count: got %0d expected 2", count); end
    endtask

    task automatic test_drain();
        out_ready = 1'b1;
        tests++; if (s !== 1'b0 || mux_f(w, s) !== 64'h1) begin failed++; $display("FAIL drain_first: got s=%b f=%h expected s=0 f=1", s, mux_f(w, s)); end
        tick();
        tests++; if (s !== 1'b1 || mux_f(w, s) !== 64'h2) begin failed++; $display("FAIL drain_second: got s=%b f=%h expected s=1 f=2", s, mux_f(w, s)); end
        tests++; if (in_ready !== 1'b1 || count !== 2'd1) begin failed++; $display("FAIL drain_reopen: got in_ready=%b count=%0d expected 1,1", in_ready, count); end
        tick();
        out_ready = 1'b0;
        tests++; if (count !== 2'd0) begin failed++; $display("FAIL drain_count: got %0d expected 0", count); end
        tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL drain_out_valid: got %b expected 0", out_valid); end
        tests++; if (s !== 1'b0) begin failed++; $display("FAIL drain_s: got %b expected 0", s); end
        tests++; if (sb.size() != 0) begin failed++; $display("FAIL drain_sb: got %0d left expected 0", sb.size()); end
    endtask

    task automatic test_back_to_back();
        logic exp_s;
        do_reset();
        pop_cnt = 0;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_data = 64'd1000 + 64'(i);
            if (i > 0) begin
                exp_s = 1'((i - 1) % 2);
                tests++; if (out_valid !== 1'b1 || s !== exp_s) begin failed++; $display("FAIL stream_beat%0d: got out_valid=%b s=%b expected 1,%b", i, out_valid, s, exp_s); end
            end
            tests++; if (in_ready !== 1'b1) begin failed++; $display("FAIL stream_in_ready%0d: got %b expected 1", i, in_ready); end
            tick();
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        tests++; if (pop_cnt != 100) begin failed++; $display("FAIL stream_total: got %0d expected 100", pop_cnt); end
        tests++; if (count !== 2'd0) begin failed++; $display("FAIL stream_count: got %0d expected 0", count); end
    endtask

    task automatic test_reset_in_full();
        do_reset();
        in_valid = 1'b1; out_ready = 1'b0;
        in_data = 64'hA; tick();
        in_data = 64'hB; tick();
        in_data = 64'hC; out_ready = 1'b1; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        sb.delete();
        tests++; if (w !== 128'h0) begin failed++; $display("FAIL rfull_w: got %h expected 0", w); end
        tests++; if (count !== 2'd0) begin failed++; $display("FAIL rfull_count: got %0d expected 0", count); end
        tests++; if (s !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin failed++; $display("FAIL rfull_ctrl: got s=%b out_valid=%b in_ready=%b expected 0,0,1", s, out_valid, in_ready); end
    endtask

`ifdef PP_FLUSH_EN
    task automatic test_flush();
        do_reset();
        in_valid = 1'b1; out_ready = 1'b0; in_data = 64'hAA;
        tick();
        in_data = 64'h5; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        sb.delete();
        tests++; if (count !== 2'd0) begin failed++; $display("FAIL flush_count: got %0d expected 0", count); end
        tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL flush_out_valid: got %b expected 0", out_valid); end
        tests++; if (w !== {64'h0, 64'hAA}) begin failed++; $display("FAIL flush_w: got %h expected {0,aa}", w); end
        tests++; if (s !== 1'b0 || in_ready !== 1'b1) begin failed++; $display("FAIL flush_ptr: got s=%b in_ready=%b expected 0,1", s, in_ready); end
    endtask
`endif

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = 64'h0;
`ifdef PP_FLUSH_EN
        flush = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        test_reset();
        test_single_push();
        test_full_backpressure();
        test_drain();
        test_back_to_back();
        test_reset_in_full();
`ifdef PP_FLUSH_EN
        test_flush();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
